branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve_pkg.sv | 40 ++++
 rtl/branch_cond_eval.sv | 30 +++
 rtl/branch_resolve.sv | 112 +++++++++++
 tb/tb_branch_resolve.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for branch resolution: FSM states, condition codes,
// flag bit positions and the PC-relative target helper.
package branch_resolve_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    RESOLVE    = 2'd2
  } br_state_e;

  typedef enum logic [2:0] {
    COND_NEQ    = 3'b000,
    COND_EQ     = 3'b001,
    COND_GT     = 3'b010,
    COND_LT     = 3'b011,
    COND_GTE    = 3'b100,
    COND_LTE    = 3'b101,
    COND_OVFL   = 3'b110,
    COND_UNCOND = 3'b111
  } br_cond_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef struct packed {
    br_cond_e    cond;
    logic        is_reg;
    logic [15:0] pc_plus2;
    logic [8:0]  imm9;
    logic [15:0] rs_val;
  } br_req_t;

  // imm9 is a signed word offset, so it is doubled into a byte offset.
  function automatic logic [15:0] rel_target(input logic [15:0] pc_plus2,
                                             input logic [8:0]  imm9);
    return pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a branch condition code against the Z/V/N flags.
module branch_cond_eval
  import branch_resolve_pkg::*;
(
  input  br_cond_e   cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      COND_NEQ:    taken = !z;
      COND_EQ:     taken = z;
      COND_GT:     taken = !z && !n;
      COND_LT:     taken = n;
      COND_GTE:    taken = z || !n;
      COND_LTE:    taken = z || n;
      COND_OVFL:   taken = v;
      COND_UNCOND: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution unit: holds one branch request, waits out pending flag
// writes (with a timeout), then resolves direction and next PC.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic             br_reg,
  input  logic [15:0]      pc_plus2,
  input  logic [8:0]       imm9,
  input  logic [15:0]      rs_val,
  input  logic [2:0]       flags,
  input  logic             flag_wr_pending,
  input  logic             kill,
  output logic             res_valid,
  output logic             taken,
  output logic [15:0]      target,
  output logic             flag_timeout,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  br_state_e         state, state_nxt;
  br_req_t           req;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cond_taken;
  logic              accept;
  logic              wait_expired;

  branch_cond_eval u_cond_eval (
    .cond  (req.cond),
    .flags (flags),
    .taken (cond_taken)
  );

  assign accept       = br_valid && br_ready && !kill;
  assign wait_expired = (state == WAIT_FLAGS) && flag_wr_pending &&
                        (wait_cnt == WAIT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       if (br_valid) state_nxt = flag_wr_pending ? WAIT_FLAGS : RESOLVE;
        WAIT_FLAGS: if (!flag_wr_pending || wait_expired) state_nxt = RESOLVE;
        RESOLVE:    state_nxt = IDLE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are gated by res_valid so target reads zero outside a resolution.
  always_comb begin
    br_ready  = (state == IDLE);
    res_valid = (state == RESOLVE) && !kill;
    taken     = res_valid && cond_taken;
    target    = 16'h0000;
    if (res_valid) begin
      if (!cond_taken)     target = req.pc_plus2;
      else if (req.is_reg) target = req.rs_val;
      else                 target = rel_target(req.pc_plus2, req.imm9);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= '0;
    end else if (accept) begin
      req <= '{cond: br_cond_e'(br_cond), is_reg: br_reg, pc_plus2: pc_plus2,
               imm9: imm9, rs_val: rs_val};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      flag_timeout <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT_FLAGS && state_nxt == WAIT_FLAGS) ? wait_cnt + 1'b1 : '0;
      if (wait_expired && !kill) flag_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (res_valid) begin
      if (taken) begin
        if (taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
      end else begin
        if (ntaken_cnt != '1) ntaken_cnt <= ntaken_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed, table-driven bench for branch_resolve; a second narrow-counter
// instance shares all inputs to exercise counter saturation.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid, br_reg, flag_wr_pending, kill;
  logic [2:0]  br_cond, flags;
  logic [15:0] pc_plus2, rs_val;
  logic [8:0]  imm9;

  logic        br_ready, res_valid, taken, flag_timeout;
  logic [15:0] target, taken_cnt, ntaken_cnt;

  logic        s_br_ready, s_res_valid, s_taken, s_flag_timeout;
  logic [15:0] s_target;
  logic [1:0]  s_taken_cnt, s_ntaken_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_taken  = 0;
  int exp_ntaken = 0;

  typedef struct {
    logic        is_reg;
    logic [2:0]  cond;
    logic [15:0] pc;
    logic [8:0]  imm;
    logic [15:0] rs;
    logic [2:0]  flg;
    logic        exp_tk;
    logic [15:0] exp_tgt;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  branch_resolve #(.CNT_W(16), .WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_reg(br_reg), .pc_plus2(pc_plus2), .imm9(imm9),
    .rs_val(rs_val), .flags(flags), .flag_wr_pending(flag_wr_pending),
    .kill(kill), .res_valid(res_valid), .taken(taken), .target(target),
    .flag_timeout(flag_timeout), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  branch_resolve #(.CNT_W(2), .WAIT_MAX(15)) dut_sat (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(s_br_ready),
    .br_cond(br_cond), .br_reg(br_reg), .pc_plus2(pc_plus2), .imm9(imm9),
    .rs_val(rs_val), .flags(flags), .flag_wr_pending(flag_wr_pending),
    .kill(kill), .res_valid(s_res_valid), .taken(s_taken), .target(s_target),
    .flag_timeout(s_flag_timeout), .taken_cnt(s_taken_cnt), .ntaken_cnt(s_ntaken_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_taken_cnt"}, taken_cnt, exp_taken);
    checkOutput({tag, "_ntaken_cnt"}, ntaken_cnt, exp_ntaken);
    checkOutput({tag, "_sat_taken_cnt"}, s_taken_cnt, sat3(exp_taken));
    checkOutput({tag, "_sat_ntaken_cnt"}, s_ntaken_cnt, sat3(exp_ntaken));
  endtask

  task automatic acceptReq(input logic is_reg, input logic [2:0] cond, input logic [15:0] pc,
                           input logic [8:0] imm, input logic [15:0] rs, input logic pend);
    br_valid = 1'b1; br_reg = is_reg; br_cond = cond;
    pc_plus2 = pc; imm9 = imm; rs_val = rs; flag_wr_pending = pend;
    nextCycle();
    br_valid = 1'b0;
  endtask

  // Hazard-free request: resolution is expected in the very next cycle.
  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    flags = v.flg;
    br_valid = 1'b1; br_reg = v.is_reg; br_cond = v.cond;
    pc_plus2 = v.pc; imm9 = v.imm; rs_val = v.rs; flag_wr_pending = 1'b0;
    #2;
    checkOutput({tag, "_ready"}, br_ready, 1);
    nextCycle();
    br_valid = 1'b0;
    #2;
    checkOutput({tag, "_res_valid"}, res_valid, 1);
    checkOutput({tag, "_taken"}, taken, v.exp_tk);
    checkOutput({tag, "_target"}, target, v.exp_tgt);
    if (v.exp_tk) exp_taken++;
    else          exp_ntaken++;
    nextCycle();
    #2;
    checkOutput({tag, "_res_done"}, res_valid, 0);
    checkOutput({tag, "_ready_back"}, br_ready, 1);
    checkCounters(tag);
    nextCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen, pulses;
    logic tk, to15, to16, rdy17;
    logic [15:0] tg;

    //          reg   cond    pc        imm     rs        flags   tk    target
    vecs[0]  = '{1'b0, 3'b001, 16'h0010, 9'h1FE, 16'h0000, 3'b100, 1'b1, 16'h000C};
    vecs[1]  = '{1'b1, 3'b011, 16'h0040, 9'h000, 16'h1234, 3'b000, 1'b0, 16'h0040};
    vecs[2]  = '{1'b0, 3'b111, 16'hFFFE, 9'h001, 16'h0000, 3'b000, 1'b1, 16'h0000};
    vecs[3]  = '{1'b0, 3'b000, 16'h0100, 9'h010, 16'h0000, 3'b000, 1'b1, 16'h0120};
    vecs[4]  = '{1'b0, 3'b000, 16'h0100, 9'h010, 16'h0000, 3'b100, 1'b0, 16'h0100};
    vecs[5]  = '{1'b1, 3'b010, 16'h2000, 9'h000, 16'hBEEF, 3'b000, 1'b1, 16'hBEEF};
    vecs[6]  = '{1'b1, 3'b010, 16'h2000, 9'h000, 16'hBEEF, 3'b001, 1'b0, 16'h2000};
    vecs[7]  = '{1'b0, 3'b100, 16'h3000, 9'h100, 16'h0000, 3'b001, 1'b0, 16'h3000};
    vecs[8]  = '{1'b0, 3'b100, 16'h3000, 9'h100, 16'h0000, 3'b101, 1'b1, 16'h2E00};
    vecs[9]  = '{1'b1, 3'b101, 16'h4000, 9'h000, 16'h5555, 3'b000, 1'b0, 16'h4000};
    vecs[10] = '{1'b1, 3'b101, 16'h4000, 9'h000, 16'h5555, 3'b001, 1'b1, 16'h5555};
    vecs[11] = '{1'b0, 3'b110, 16'h1000, 9'h0FF, 16'h0000, 3'b010, 1'b1, 16'h11FE};
    vecs[12] = '{1'b0, 3'b110, 16'h1000, 9'h0FF, 16'h0000, 3'b101, 1'b0, 16'h1000};
    vecs[13] = '{1'b0, 3'b011, 16'h8000, 9'h000, 16'h0000, 3'b001, 1'b1, 16'h8000};
    vecs[14] = '{1'b0, 3'b001, 16'h7FFE, 9'h000, 16'h0000, 3'b011, 1'b0, 16'h7FFE};

    br_valid = 1'b0; br_reg = 1'b0; br_cond = 3'b000; pc_plus2 = 16'h0;
    imm9 = 9'h0; rs_val = 16'h0; flags = 3'b000; flag_wr_pending = 1'b0; kill = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    checkOutput("rst_ready", br_ready, 1);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_taken", taken, 0);
    checkOutput("rst_target", target, 0);
    checkOutput("rst_timeout", flag_timeout, 0);
    checkCounters("rst");
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    for (int i = 0; i < 15; i++) applyStimulus(i, vecs[i]);

    // Flags become valid two cycles into the hazard; OVFL must see the late V.
    flags = 3'b000;
    acceptReq(1'b0, 3'b110, 16'h0200, 9'h004, 16'h0000, 1'b1);
    seen = 0; tk = 1'b0; tg = 16'h0;
    for (int k = 1; k <= 8; k++) begin
      flag_wr_pending = (k < 3);
      flags = (k >= 2) ? 3'b010 : 3'b000;
      #2;
      if (res_valid && seen == 0) begin seen = k; tk = taken; tg = target; end
      nextCycle();
    end
    checkOutput("haz_latency", seen, 4);
    checkOutput("haz_taken", tk, 1);
    checkOutput("haz_target", tg, 16'h0208);
    exp_taken++;
    flag_wr_pending = 1'b0;
    #2;
    checkCounters("haz");
    nextCycle();

    // Flag write never completes: timeout after 15 wait cycles.
    checkOutput("to_before", flag_timeout, 0);
    acceptReq(1'b1, 3'b111, 16'h0000, 9'h000, 16'hCAFE, 1'b1);
    seen = 0; pulses = 0; tg = 16'h0; to15 = 1'b1; to16 = 1'b0; rdy17 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      flag_wr_pending = 1'b1;
      #2;
      if (k == 15) to15 = flag_timeout;
      if (k == 16) to16 = flag_timeout;
      if (k == 17) rdy17 = br_ready;
      if (res_valid) begin
        pulses++;
        if (seen == 0) begin seen = k; tg = target; end
      end
      nextCycle();
    end
    checkOutput("to_not_early", to15, 0);
    checkOutput("to_set", to16, 1);
    checkOutput("to_res_cycle", seen, 16);
    checkOutput("to_res_pulses", pulses, 1);
    checkOutput("to_target", tg, 16'hCAFE);
    checkOutput("to_ready_back", rdy17, 1);
    exp_taken++;
    flag_wr_pending = 1'b0;
    #2;
    checkOutput("to_sticky", flag_timeout, 1);
    checkCounters("to");
    nextCycle();

    // kill while waiting for flags.
    acceptReq(1'b0, 3'b111, 16'h0400, 9'h000, 16'h0000, 1'b1);
    #2;
    checkOutput("killw_busy", br_ready, 0);
    nextCycle();
    kill = 1'b1;
    #2;
    checkOutput("killw_res_valid", res_valid, 0);
    nextCycle();
    kill = 1'b0; flag_wr_pending = 1'b0;
    #2;
    checkOutput("killw_idle", br_ready, 1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (res_valid) pulses++;
      nextCycle();
      #2;
    end
    checkOutput("killw_no_res", pulses, 0);
    checkCounters("killw");
    nextCycle();

    // kill in the resolve cycle wins over the resolution.
    flags = 3'b000;
    acceptReq(1'b0, 3'b111, 16'h0500, 9'h000, 16'h0000, 1'b0);
    kill = 1'b1;
    #2;
    checkOutput("killr_res_valid", res_valid, 0);
    checkOutput("killr_taken", taken, 0);
    nextCycle();
    kill = 1'b0;
    #2;
    checkOutput("killr_idle", br_ready, 1);
    checkOutput("killr_res_after", res_valid, 0);
    checkCounters("killr");
    nextCycle();

    // kill together with a new request: nothing is accepted.
    br_valid = 1'b1; br_reg = 1'b0; br_cond = 3'b111; pc_plus2 = 16'h0600; kill = 1'b1;
    nextCycle();
    br_valid = 1'b0; kill = 1'b0;
    #2;
    checkOutput("killa_idle", br_ready, 1);
    checkOutput("killa_res_valid", res_valid, 0);
    nextCycle();
    #2;
    checkOutput("killa_res_later", res_valid, 0);
    checkCounters("killa");
    nextCycle();

    // A second request presented while busy must not replace the held one.
    flags = 3'b000;
    acceptReq(1'b0, 3'b001, 16'h0300, 9'h010, 16'h0000, 1'b1);
    br_valid = 1'b1; br_reg = 1'b1; br_cond = 3'b111; rs_val = 16'h9999; pc_plus2 = 16'h5000;
    nextCycle();
    flag_wr_pending = 1'b0;
    nextCycle();
    br_valid = 1'b0;
    #2;
    checkOutput("busy_res_valid", res_valid, 1);
    checkOutput("busy_taken", taken, 0);
    checkOutput("busy_target", target, 16'h0300);
    exp_ntaken++;
    nextCycle();
    #2;
    checkOutput("busy_ready_back", br_ready, 1);
    checkCounters("busy");
    nextCycle();

    // Asynchronous reset in the middle of a flag wait.
    acceptReq(1'b1, 3'b111, 16'h0000, 9'h000, 16'h1111, 1'b1);
    nextCycle();
    rst_n = 1'b0;
    #2;
    exp_taken = 0; exp_ntaken = 0;
    checkOutput("rstw_ready", br_ready, 1);
    checkOutput("rstw_res_valid", res_valid, 0);
    checkOutput("rstw_target", target, 0);
    checkOutput("rstw_timeout", flag_timeout, 0);
    checkCounters("rstw");
    nextCycle();
    rst_n = 1'b1; flag_wr_pending = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      #2;
      if (res_valid) pulses++;
      nextCycle();
    end
    checkOutput("rstw_no_res", pulses, 0);
    checkCounters("rstw_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
